// File: rtl/round_robin_arbiter.sv
// Registered rotating-priority arbiter: one-hot or zero grant, 1-cycle latency, no request backpressure.
// Define ROUND_ROBIN_ARBITER_TIMEOUT_EN to add the p_MAX_HOLD limit with forced rearbitration.
module round_robin_arbiter #(
   parameter int p_WIDTH    = 4,
   parameter int p_MAX_HOLD = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [p_WIDTH-1:0] iv_req,
   output logic [p_WIDTH-1:0] ov_grant,
   output logic               o_grant_valid,
   output logic               o_forced
);
   localparam int LW = $clog2(p_WIDTH);

   logic [p_WIDTH-1:0] r_grant;
   logic               r_valid;
   logic [LW-1:0]      r_last;

   logic               w_busy;
   logic               w_hold_req;
   logic               w_timeout;
   logic               w_rearb;
   logic [p_WIDTH-1:0] w_mask_req;
   logic [p_WIDTH-1:0] w_arb_grant;
   logic [LW-1:0]      w_arb_idx;

   if (p_WIDTH < 2 || p_MAX_HOLD < 1) begin : g_param_check
      $error("round_robin_arbiter: need p_WIDTH >= 2 and p_MAX_HOLD >= 1");
   end

   assign w_busy     = |r_grant;
   assign w_hold_req = |(iv_req & r_grant);
   assign w_rearb    = !w_busy || !w_hold_req || w_timeout;
   // On a timeout the current holder is still requesting, so it must be masked out.
   assign w_mask_req = w_timeout ? (iv_req & ~r_grant) : iv_req;

   always_comb begin
      logic [LW-1:0] w_pos;
      w_arb_grant = '0;
      w_arb_idx   = '0;
      w_pos       = '0;
      for (int i = 1; i <= p_WIDTH; i++) begin
         w_pos = LW'((int'(r_last) + i) % p_WIDTH);
         if (w_mask_req[w_pos] && (w_arb_grant == '0)) begin
            w_arb_grant[w_pos] = 1'b1;
            w_arb_idx          = w_pos;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_grant <= '0;
         r_valid <= 1'b0;
         r_last  <= LW'(p_WIDTH - 1);
      end else if (w_rearb) begin
         r_grant <= w_arb_grant;
         r_valid <= |w_arb_grant;
         if (|w_arb_grant) begin
            r_last <= w_arb_idx;
         end
      end
   end

`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
   localparam int            HW        = $clog2(p_MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(p_MAX_HOLD - 1);

   logic [HW-1:0] r_hold_cnt;
   logic          r_forced;
   logic          w_hold_last;

   assign w_hold_last = (r_hold_cnt == HOLD_LAST);
   assign w_timeout   = w_busy && w_hold_req && w_hold_last && (|(iv_req & ~r_grant));

   // A sole requester at the limit just restarts its hold window.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_cnt <= '0;
         r_forced   <= 1'b0;
      end else begin
         r_forced <= w_timeout;
         if (w_rearb || w_hold_last) begin
            r_hold_cnt <= '0;
         end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   assign o_forced = r_forced;
`else
   assign w_timeout = 1'b0;
   assign o_forced  = 1'b0;
`endif

   assign ov_grant      = r_grant;
   assign o_grant_valid = r_valid;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed test-plan sequences plus random traffic against a queued model.
module tb_round_robin_arbiter;
   localparam int W    = 4;
   localparam int MAXH = 4;
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] grant;
      logic         vld;
      logic         forced;
   } exp_t;

   logic         core_clk = 1'b0;
   logic         rst      = 1'b1;
   logic [W-1:0] req_dat  = '0;
   logic [W-1:0] grant_dat;
   logic         grant_vld;
   logic         forced;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_hold   = -1;
   int   m_last   = W - 1;
   int   m_cnt    = 0;
   bit   m_forced = 1'b0;

   always #5 core_clk = ~core_clk;

   round_robin_arbiter #(.p_WIDTH(W), .p_MAX_HOLD(MAXH)) dut (
      .i_clk        (core_clk),
      .i_rst        (rst),
      .iv_req       (req_dat),
      .ov_grant     (grant_dat),
      .o_grant_valid(grant_vld),
      .o_forced     (forced)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour, advanced once per sampled edge.
   task automatic model_edge(input logic [W-1:0] req, input bit r);
      bit timeout;
      int pick;
      int c;
      if (r) begin
         m_hold = -1; m_last = W - 1; m_cnt = 0; m_forced = 1'b0;
         return;
      end
      timeout = TO_EN && (m_hold >= 0) && req[m_hold] && (m_cnt == MAXH - 1)
                && ((req & ~(W'(1) << m_hold)) != '0);
      m_forced = timeout;
      if (m_hold < 0 || !req[m_hold] || timeout) begin
         pick = -1;
         for (int k = 1; k <= W; k++) begin
            c = (m_last + k) % W;
            if (pick < 0 && req[c] && !(timeout && c == m_hold)) pick = c;
         end
         m_hold = pick;
         if (pick >= 0) m_last = pick;
         m_cnt = 0;
      end else if (TO_EN && m_cnt == MAXH - 1) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic step(input logic [W-1:0] req, input bit r);
      exp_t e;
      @(negedge core_clk);
      req_dat = req;
      rst     = r;
      model_edge(req, r);
      e.grant  = (m_hold >= 0) ? (W'(1) << m_hold) : '0;
      e.vld    = (m_hold >= 0);
      e.forced = m_forced;
      exp_q.push_back(e);
      @(posedge core_clk);
      #1;
      e = exp_q.pop_front();
      check("sb_grant", 32'(grant_dat), 32'(e.grant));
      check("sb_valid", 32'(grant_vld), 32'(e.vld));
      check("sb_forced", 32'(forced), 32'(e.forced));
      check("onehot0", 32'($onehot0(grant_dat)), 32'd1);
   endtask

   initial begin
      // Reset and idle
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      check("rst_grant", 32'(grant_dat), 32'h0);
      check("rst_valid", 32'(grant_vld), 32'h0);
      check("rst_forced", 32'(forced), 32'h0);
      step(4'b1111, 1'b0);
      check("first_grant", 32'(grant_dat), 32'h1);

      // Rotation with no dead cycle
      for (int h = 0; h < W; h++) begin
         step(4'b1111, 1'b0);
         check("rot_hold", 32'(grant_dat), 32'(1 << h));
         step(4'b1111 & ~(4'b0001 << h), 1'b0);
         check("rot_next", 32'(grant_dat), 32'(1 << ((h + 1) % W)));
         check("rot_vld", 32'(grant_vld), 32'h1);
      end
      step(4'b1111, 1'b0);

      // Skip and wrap from L=2
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      check("skip_setup", 32'(grant_dat), 32'h4);
      step(4'b0010, 1'b0);
      check("skip_grant", 32'(grant_dat), 32'h2);
      step(4'b0001, 1'b0);
      check("wrap_grant", 32'(grant_dat), 32'h1);

      // Reset while holding
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      step(4'b1111, 1'b0);
      check("midrst_pre", 32'(grant_dat), 32'h4);
      step(4'b1111, 1'b1);
      check("midrst_grant", 32'(grant_dat), 32'h0);
      step(4'b1111, 1'b0);
      check("midrst_restart", 32'(grant_dat), 32'h1);

      // Hold limit with a competing requester
      step(4'b0000, 1'b1);
      for (int i = 0; i < MAXH; i++) begin
         step(4'b0011, 1'b0);
         check("to_hold", 32'(grant_dat), 32'h1);
         check("to_nopulse", 32'(forced), 32'h0);
      end
      step(4'b0011, 1'b0);
      check("to_grant", 32'(grant_dat), TO_EN ? 32'h2 : 32'h1);
      check("to_pulse", 32'(forced), TO_EN ? 32'h1 : 32'h0);
      step(4'b0011, 1'b0);
      check("to_after", 32'(grant_dat), TO_EN ? 32'h2 : 32'h1);
      check("to_pulse_end", 32'(forced), 32'h0);

      // Sole requester never loses the grant
      step(4'b0000, 1'b1);
      for (int i = 0; i < 3 * MAXH; i++) begin
         step(4'b0001, 1'b0);
         check("sole_grant", 32'(grant_dat), 32'h1);
         check("sole_forced", 32'(forced), 32'h0);
      end

      // Random traffic, mostly sticky requests so holds get long
      begin
         logic [W-1:0] r = '0;
         for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < W; b++) begin
               if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            step(r, ($urandom_range(0, 60) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end
endmodule
